cg_tlb_setassociative: RTL and testbench
========================================

// Module: cg_tlb_setassociative
// PURPOSE
//  Set-associative, ASID-tagged TLB with integrated page-table-walk (PTW) miss FSM, global pages and selective flush.
//  Sits between core address-generation and the PTW. One outstanding request; hits return 1 cycle after acceptance.
//  Per-set Bit-PLRU replacement; invalid ways are filled first.
// PARAMETERS
//  VADDR_WIDTH   39  virtual address width
//  PADDR_WIDTH   56  physical address width
//  OFFSET_WIDTH  12  page offset width; VPN=VADDR_WIDTH-OFFSET_WIDTH, PPN=PADDR_WIDTH-OFFSET_WIDTH (localparams)
//  ASID_WIDTH    16  address-space ID width
//  WAYS          4   ways per set, power of 2, >=1
//  SETS          16  sets, power of 2, >=1; index=VPN[log2(SETS)-1:0], tag=remaining VPN MSBs
// PORTS
//  i_clk            in   1            clock
//  i_rstn           in   1            reset, asynchronous, active-low
//  i_req_valid      in   1            lookup request
//  o_req_ready      out  1            request accepted when valid&ready
//  i_vaddr          in   VADDR_WIDTH  virtual address
//  i_asid           in   ASID_WIDTH   requesting ASID
//  o_resp_valid     out  1            1-cycle response pulse
//  o_resp_paddr     out  PADDR_WIDTH  {PPN, offset}; 0 when o_resp_fault
//  o_resp_fault     out  1            PTW reported page fault
//  o_ptw_req_valid  out  1            walk request, held until ready
//  i_ptw_req_ready  in   1            PTW accepts walk
//  o_ptw_req_vaddr  out  VADDR_WIDTH  vaddr to walk
//  i_ptw_resp_valid in   1            walk result pulse
//  i_ptw_resp_ppn   in   PPN          translated PPN
//  i_ptw_resp_global in  1            page is global (matches any ASID)
//  i_ptw_resp_fault in   1            walk faulted
//  i_flush_valid    in   1            flush command (accepted only in IDLE)
//  i_flush_asid_en  in   1            restrict flush to i_flush_asid (non-global entries only)
//  i_flush_asid     in   ASID_WIDTH   ASID filter
//  i_flush_vaddr_en in   1            restrict flush to VPN of i_flush_vaddr
//  i_flush_vaddr    in   VADDR_WIDTH  vaddr filter
//  o_flush_done     out  1            1-cycle pulse, cycle after flush accepted
// BEHAVIOUR
//  Reset: all valid bits, PLRU bits 0; FSM=IDLE; every output 0 except o_req_ready=1. Reset mid-walk abandons walk; late PTW resp ignored.
//  Hit: valid & tag== & (global | asid==). Multiple hits (illegal): lowest way wins. Request registered on accept.
//  FSM IDLE: o_req_ready=~i_flush_valid. Flush has priority over same-cycle request -> FLUSH. Accept -> LOOKUP.
//  LOOKUP (1 cycle): hit -> o_resp_valid, paddr={PPN,offset}, mark way MRU, ->IDLE. Miss -> PTW_REQ.
//  PTW_REQ: o_ptw_req_valid=1, vaddr stable until i_ptw_req_ready; -> PTW_WAIT.
//  PTW_WAIT: on i_ptw_resp_valid -> FILL, latching ppn/global/fault. resp_valid before req handshake is ignored.
//  FILL (1 cycle): fault -> o_resp_valid+o_resp_fault, no write. Else write victim way {tag,asid,ppn,global,valid=1},
//   mark MRU, o_resp_valid with new paddr. Victim = lowest invalid way in set, else lowest way with PLRU bit 0. ->IDLE.
//  FLUSH (1 cycle): clear valid where (!asid_en | (!global & asid==)) & (!vaddr_en | VPN==); clear all PLRU bits of any set
//   left fully invalid; o_flush_done next cycle; ->IDLE. asid_en=vaddr_en=0: flush all incl. global.
//  PLRU: per set, WAYS bits; set on hit/fill; if that makes all 1s, set becomes one-hot of accessed way.
//  Hit latency 1 cycle; miss latency = PTW latency + 3 cycles min. o_resp_valid, o_flush_done never both high.
// TESTING (WAYS=2, SETS=4 unless noted)
//  Cold miss va=0x0000_5123 asid=1 -> ptw_req_vaddr=0x5123; PTW ppn=0xAB -> resp paddr=0xAB123; replay -> hit, 1-cycle latency.
//  Fill ways 0/1 of set 1, hit way 0, miss new tag in set 1 -> way 1 evicted, way 0 still hits.
//  Global ppn 0x77 filled asid=1; lookup asid=2 -> hit 0x77xxx; flush asid_en asid=1 -> still hits; flush all -> misses.
//  Flush vaddr_en va=0x5000 with 0x5000/0x6000 cached -> 0x5000 misses, 0x6000 hits; o_flush_done 1 cycle after accept.
//  PTW fault -> o_resp_fault=1, paddr=0, no fill (replay misses again); i_ptw_req_ready held low 10 cycles -> req stable.
//  Assert i_rstn=0 in PTW_WAIT, then PTW resp -> ignored, outputs 0, o_req_ready=1, all lookups miss.

Source files
------------

// File: rtl/cg_tlb_setassociative_if.sv
// Core/PTW/flush bus of the set-associative TLB.
// The TLB sits on the slave side; the core and PTW together form the master side.
interface cg_tlb_setassociative_if #(
  parameter int VADDR_WIDTH  = 39,
  parameter int PADDR_WIDTH  = 56,
  parameter int OFFSET_WIDTH = 12,
  parameter int ASID_WIDTH   = 16
);
  localparam int PPN_WIDTH = PADDR_WIDTH - OFFSET_WIDTH;

  logic                   i_req_valid;
  logic                   o_req_ready;
  logic [VADDR_WIDTH-1:0] i_vaddr;
  logic [ASID_WIDTH-1:0]  i_asid;
  logic                   o_resp_valid;
  logic [PADDR_WIDTH-1:0] o_resp_paddr;
  logic                   o_resp_fault;
  logic                   o_ptw_req_valid;
  logic                   i_ptw_req_ready;
  logic [VADDR_WIDTH-1:0] o_ptw_req_vaddr;
  logic                   i_ptw_resp_valid;
  logic [PPN_WIDTH-1:0]   i_ptw_resp_ppn;
  logic                   i_ptw_resp_global;
  logic                   i_ptw_resp_fault;
  logic                   i_flush_valid;
  logic                   i_flush_asid_en;
  logic [ASID_WIDTH-1:0]  i_flush_asid;
  logic                   i_flush_vaddr_en;
  logic [VADDR_WIDTH-1:0] i_flush_vaddr;
  logic                   o_flush_done;

  modport slave (
    input  i_req_valid, i_vaddr, i_asid, i_ptw_req_ready, i_ptw_resp_valid,
           i_ptw_resp_ppn, i_ptw_resp_global, i_ptw_resp_fault, i_flush_valid,
           i_flush_asid_en, i_flush_asid, i_flush_vaddr_en, i_flush_vaddr,
    output o_req_ready, o_resp_valid, o_resp_paddr, o_resp_fault,
           o_ptw_req_valid, o_ptw_req_vaddr, o_flush_done
  );

  modport master (
    output i_req_valid, i_vaddr, i_asid, i_ptw_req_ready, i_ptw_resp_valid,
           i_ptw_resp_ppn, i_ptw_resp_global, i_ptw_resp_fault, i_flush_valid,
           i_flush_asid_en, i_flush_asid, i_flush_vaddr_en, i_flush_vaddr,
    input  o_req_ready, o_resp_valid, o_resp_paddr, o_resp_fault,
           o_ptw_req_valid, o_ptw_req_vaddr, o_flush_done
  );
endinterface

// File: rtl/cg_tlb_setassociative.sv
// Set-associative ASID-tagged TLB with PTW miss handling, global pages,
// selective flush and per-set bit-PLRU replacement (invalid ways filled first).
module cg_tlb_setassociative #(
  parameter int VADDR_WIDTH  = 39,
  parameter int PADDR_WIDTH  = 56,
  parameter int OFFSET_WIDTH = 12,
  parameter int ASID_WIDTH   = 16,
  parameter int WAYS         = 4,
  parameter int SETS         = 16
) (
  input logic                     i_clk,
  input logic                     i_rstn,
  cg_tlb_setassociative_if.slave  bus
);
  localparam int VPN_W    = VADDR_WIDTH - OFFSET_WIDTH;
  localparam int PPN_W    = PADDR_WIDTH - OFFSET_WIDTH;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_W    = VPN_W - IDX_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, PTW_REQ, PTW_WAIT, FILL, FLUSH} state_t;
  state_t state_reg, state_next;

  logic [WAYS-1:0]       valid_reg [SETS];
  logic [WAYS-1:0]       plru_reg  [SETS];
  logic [WAYS-1:0]       glob_reg  [SETS];
  logic [TAG_W-1:0]      tag_reg   [SETS][WAYS];
  logic [ASID_WIDTH-1:0] asid_reg  [SETS][WAYS];
  logic [PPN_W-1:0]      ppn_reg   [SETS][WAYS];

  logic [VADDR_WIDTH-1:0] req_vaddr_reg;
  logic [ASID_WIDTH-1:0]  req_asid_reg;
  logic [PPN_W-1:0]       walk_ppn_reg;
  logic                   walk_glob_reg, walk_fault_reg;
  logic                   fl_asid_en_reg, fl_vaddr_en_reg;
  logic [ASID_WIDTH-1:0]  fl_asid_reg;
  logic [VPN_W-1:0]       fl_vpn_reg;

  logic [VPN_W-1:0] req_vpn;
  logic [IDX_W-1:0] req_set, fl_set;
  logic [TAG_W-1:0] req_tag, fl_tag;
  assign req_vpn = req_vaddr_reg[VADDR_WIDTH-1:OFFSET_WIDTH];
  assign req_set = IDX_W'(req_vpn & VPN_W'(SETS - 1));
  assign req_tag = TAG_W'(req_vpn >> IDX_BITS);
  assign fl_set  = IDX_W'(fl_vpn_reg & VPN_W'(SETS - 1));
  assign fl_tag  = TAG_W'(fl_vpn_reg >> IDX_BITS);

  logic [WAYS-1:0] hit_vec;
  logic [WAYS-1:0] flush_hit [SETS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = valid_reg[req_set][gi] && (tag_reg[req_set][gi] == req_tag) &&
                           (glob_reg[req_set][gi] || (asid_reg[req_set][gi] == req_asid_reg));
    end
    for (gi = 0; gi < SETS; gi++) begin : g_fset
      logic [WAYS-1:0] fh;
      for (gj = 0; gj < WAYS; gj++) begin : g_fway
        // Global pages survive an ASID-filtered flush.
        assign fh[gj] = (!fl_asid_en_reg || (!glob_reg[gi][gj] && asid_reg[gi][gj] == fl_asid_reg)) &&
                        (!fl_vaddr_en_reg || (tag_reg[gi][gj] == fl_tag && fl_set == IDX_W'(gi)));
      end
      assign flush_hit[gi] = fh;
    end
  endgenerate

  logic [WAY_W-1:0] hit_way, victim_way, touch_way;
  logic [WAYS-1:0]  plru_or, plru_new;
  logic             hit_any, fill_en, touch_en;

  always_comb begin
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) if (hit_vec[w]) hit_way = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--) if (!plru_reg[req_set][w]) victim_way = WAY_W'(w);
    // Invalid ways override the PLRU choice.
    for (int w = WAYS - 1; w >= 0; w--) if (!valid_reg[req_set][w]) victim_way = WAY_W'(w);
  end

  assign hit_any   = |hit_vec;
  assign fill_en   = (state_reg == FILL) && !walk_fault_reg;
  assign touch_en  = ((state_reg == LOOKUP) && hit_any) || fill_en;
  assign touch_way = (state_reg == LOOKUP) ? hit_way : victim_way;
  assign plru_or   = plru_reg[req_set] | (WAYS'(1) << touch_way);
  assign plru_new  = (&plru_or) ? (WAYS'(1) << touch_way) : plru_or;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (state_reg == FLUSH) begin
        for (int s = 0; s < SETS; s++) begin
          valid_reg[s] <= valid_reg[s] & ~flush_hit[s];
          if ((valid_reg[s] & ~flush_hit[s]) == '0) plru_reg[s] <= '0;
        end
      end
      if (fill_en) valid_reg[req_set][victim_way] <= 1'b1;
      if (touch_en) plru_reg[req_set] <= plru_new;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_reg == IDLE && !bus.i_flush_valid && bus.i_req_valid) begin
      req_vaddr_reg <= bus.i_vaddr;
      req_asid_reg  <= bus.i_asid;
    end
    if (state_reg == IDLE && bus.i_flush_valid) begin
      fl_asid_en_reg  <= bus.i_flush_asid_en;
      fl_asid_reg     <= bus.i_flush_asid;
      fl_vaddr_en_reg <= bus.i_flush_vaddr_en;
      fl_vpn_reg      <= bus.i_flush_vaddr[VADDR_WIDTH-1:OFFSET_WIDTH];
    end
    if (state_reg == PTW_WAIT && bus.i_ptw_resp_valid) begin
      walk_ppn_reg   <= bus.i_ptw_resp_ppn;
      walk_glob_reg  <= bus.i_ptw_resp_global;
      walk_fault_reg <= bus.i_ptw_resp_fault;
    end
    if (fill_en) begin
      tag_reg[req_set][victim_way]  <= req_tag;
      asid_reg[req_set][victim_way] <= req_asid_reg;
      ppn_reg[req_set][victim_way]  <= walk_ppn_reg;
      glob_reg[req_set][victim_way] <= walk_glob_reg;
    end
  end

  always_comb begin
    state_next          = state_reg;
    bus.o_req_ready     = 1'b0;
    bus.o_resp_valid    = 1'b0;
    bus.o_resp_paddr    = '0;
    bus.o_resp_fault    = 1'b0;
    bus.o_ptw_req_valid = 1'b0;
    bus.o_ptw_req_vaddr = '0;
    bus.o_flush_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.o_req_ready = !bus.i_flush_valid;
        if (bus.i_flush_valid)    state_next = FLUSH;
        else if (bus.i_req_valid) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (hit_any) begin
          bus.o_resp_valid = 1'b1;
          bus.o_resp_paddr = {ppn_reg[req_set][hit_way], req_vaddr_reg[OFFSET_WIDTH-1:0]};
          state_next       = IDLE;
        end else begin
          state_next = PTW_REQ;
        end
      end
      PTW_REQ: begin
        bus.o_ptw_req_valid = 1'b1;
        bus.o_ptw_req_vaddr = req_vaddr_reg;
        if (bus.i_ptw_req_ready) state_next = PTW_WAIT;
      end
      PTW_WAIT: if (bus.i_ptw_resp_valid) state_next = FILL;
      FILL: begin
        bus.o_resp_valid = 1'b1;
        bus.o_resp_fault = walk_fault_reg;
        if (!walk_fault_reg) bus.o_resp_paddr = {walk_ppn_reg, req_vaddr_reg[OFFSET_WIDTH-1:0]};
        state_next = IDLE;
      end
      FLUSH: begin
        bus.o_flush_done = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cg_tlb_setassociative.sv
// Directed and randomized checks of cg_tlb_setassociative (WAYS=2, SETS=4)
// against an entry-list reference model of the TLB.
module tb_cg_tlb_setassociative;
  localparam int VA_W  = 39;
  localparam int PA_W  = 56;
  localparam int OFF_W = 12;
  localparam int AS_W  = 16;
  localparam int PPN_W = PA_W - OFF_W;
  localparam int VPN_W = VA_W - OFF_W;
  localparam int WAYS  = 2;
  localparam int SETS  = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cg_tlb_setassociative_if tif ();
  cg_tlb_setassociative #(.WAYS(WAYS), .SETS(SETS)) dut (.i_clk(clk), .i_rstn(rstn), .bus(tif));

  int checks   = 0;
  int failures = 0;

  // Reference model: each slot holds a full VPN; a set is VPN modulo SETS.
  bit               m_v   [SETS][WAYS];
  bit               m_g   [SETS][WAYS];
  bit               m_pl  [SETS][WAYS];
  logic [VPN_W-1:0] m_vpn [SETS][WAYS];
  logic [AS_W-1:0]  m_as  [SETS][WAYS];
  logic [PPN_W-1:0] m_ppn [SETS][WAYS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w]  = 1'b0;
        m_pl[s][w] = 1'b0;
      end
  endfunction

  function automatic int m_find(logic [VPN_W-1:0] vpn, logic [AS_W-1:0] asid);
    int s = int'(vpn % SETS);
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_vpn[s][w] == vpn && (m_g[s][w] || m_as[s][w] == asid)) return w;
    return -1;
  endfunction

  function automatic void m_touch(int s, int w);
    bit all = 1'b1;
    m_pl[s][w] = 1'b1;
    for (int i = 0; i < WAYS; i++) if (!m_pl[s][i]) all = 1'b0;
    if (all) begin
      for (int i = 0; i < WAYS; i++) m_pl[s][i] = 1'b0;
      m_pl[s][w] = 1'b1;
    end
  endfunction

  function automatic int m_victim(int s);
    for (int w = 0; w < WAYS; w++) if (!m_v[s][w]) return w;
    for (int w = 0; w < WAYS; w++) if (!m_pl[s][w]) return w;
    return 0;
  endfunction

  function automatic void m_flush(bit ae, logic [AS_W-1:0] as, bit ve, logic [VPN_W-1:0] vpn);
    bit any;
    for (int s = 0; s < SETS; s++) begin
      any = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (m_v[s][w] && (!ae || (!m_g[s][w] && m_as[s][w] == as)) && (!ve || m_vpn[s][w] == vpn))
          m_v[s][w] = 1'b0;
        if (m_v[s][w]) any = 1'b1;
      end
      if (!any) for (int w = 0; w < WAYS; w++) m_pl[s][w] = 1'b0;
    end
  endfunction

  task automatic lookup(input logic [VA_W-1:0] va, input logic [AS_W-1:0] asid,
                        input logic [PPN_W-1:0] ppn, input bit g, input bit f,
                        input int hold, input int dly,
                        output bit hit_o, output logic [PA_W-1:0] pa_o);
    logic [VPN_W-1:0] vpn;
    int s, w, v;
    vpn = va[VA_W-1:OFF_W];
    s   = int'(vpn % SETS);
    w   = m_find(vpn, asid);
    @(negedge clk);
    chk("idle_ready", tif.o_req_ready, 1);
    tif.i_req_valid = 1'b1;
    tif.i_vaddr     = va;
    tif.i_asid      = asid;
    @(negedge clk);
    tif.i_req_valid = 1'b0;
    hit_o = tif.o_resp_valid;
    pa_o  = tif.o_resp_paddr;
    chk("lookup_hit", tif.o_resp_valid, (w >= 0));
    if (w >= 0) begin
      chk("hit_paddr", tif.o_resp_paddr, {m_ppn[s][w], va[OFF_W-1:0]});
      m_touch(s, w);
    end else begin
      @(negedge clk);
      for (int k = 0; k <= hold; k++) begin
        chk("ptw_req_valid", tif.o_ptw_req_valid, 1);
        chk("ptw_req_vaddr", tif.o_ptw_req_vaddr, va);
        if (k == hold) tif.i_ptw_req_ready = 1'b1;
        else if (k == 0 && hold > 1) begin
          tif.i_ptw_resp_valid = 1'b1;   // premature result, must be ignored
          tif.i_ptw_resp_ppn   = ~ppn;
        end
        @(negedge clk);
        tif.i_ptw_req_ready  = 1'b0;
        tif.i_ptw_resp_valid = 1'b0;
      end
      chk("ptw_req_dropped", tif.o_ptw_req_valid, 0);
      repeat (dly) @(negedge clk);
      tif.i_ptw_resp_valid  = 1'b1;
      tif.i_ptw_resp_ppn    = ppn;
      tif.i_ptw_resp_global = g;
      tif.i_ptw_resp_fault  = f;
      @(negedge clk);
      tif.i_ptw_resp_valid = 1'b0;
      pa_o = tif.o_resp_paddr;
      chk("fill_resp_valid", tif.o_resp_valid, 1);
      chk("fill_fault", tif.o_resp_fault, f);
      chk("fill_paddr", tif.o_resp_paddr, f ? '0 : {ppn, va[OFF_W-1:0]});
      chk("fill_no_done", tif.o_flush_done, 0);
      if (!f) begin
        v = m_victim(s);
        m_v[s][v]   = 1'b1;
        m_g[s][v]   = g;
        m_vpn[s][v] = vpn;
        m_as[s][v]  = asid;
        m_ppn[s][v] = ppn;
        m_touch(s, v);
      end
    end
  endtask

  task automatic flush(input bit ae, input logic [AS_W-1:0] as, input bit ve, input logic [VA_W-1:0] va);
    @(negedge clk);
    tif.i_flush_valid    = 1'b1;
    tif.i_flush_asid_en  = ae;
    tif.i_flush_asid     = as;
    tif.i_flush_vaddr_en = ve;
    tif.i_flush_vaddr    = va;
    tif.i_req_valid      = 1'b1;   // competing request loses to the flush
    #1;
    chk("flush_blocks_req", tif.o_req_ready, 0);
    @(negedge clk);
    tif.i_flush_valid = 1'b0;
    tif.i_req_valid   = 1'b0;
    chk("flush_done", tif.o_flush_done, 1);
    chk("flush_no_resp", tif.o_resp_valid, 0);
    m_flush(ae, as, ve, va[VA_W-1:OFF_W]);
    @(negedge clk);
    chk("flush_done_pulse", tif.o_flush_done, 0);
    chk("flush_no_accept", tif.o_resp_valid, 0);
  endtask

  bit               hit;
  logic [PA_W-1:0]  pa;
  logic [VPN_W-1:0] rvpn;
  logic [VA_W-1:0]  rva;

  initial begin
    tif.i_req_valid = 0; tif.i_vaddr = '0; tif.i_asid = '0;
    tif.i_ptw_req_ready = 0; tif.i_ptw_resp_valid = 0; tif.i_ptw_resp_ppn = '0;
    tif.i_ptw_resp_global = 0; tif.i_ptw_resp_fault = 0;
    tif.i_flush_valid = 0; tif.i_flush_asid_en = 0; tif.i_flush_asid = '0;
    tif.i_flush_vaddr_en = 0; tif.i_flush_vaddr = '0;
    m_clear();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", tif.o_req_ready, 1);
    chk("rst_resp_valid", tif.o_resp_valid, 0);
    chk("rst_ptw_req_valid", tif.o_ptw_req_valid, 0);
    chk("rst_flush_done", tif.o_flush_done, 0);
    chk("rst_paddr", tif.o_resp_paddr, 0);
    rstn = 1'b1;

    // Cold miss then replay hit
    lookup(39'h5123, 16'd1, 44'hAB, 0, 0, 0, 1, hit, pa);
    chk("cold_is_miss", hit, 0);
    chk("cold_paddr", pa, 56'hAB123);
    lookup(39'h5123, 16'd1, 44'h0, 0, 0, 0, 0, hit, pa);
    chk("replay_hit", hit, 1);
    chk("replay_paddr", pa, 56'hAB123);

    // PLRU eviction within set 1
    flush(0, 0, 0, 0);
    lookup(39'h5000, 16'd1, 44'h10, 0, 0, 0, 0, hit, pa);
    lookup(39'h9000, 16'd1, 44'h20, 0, 0, 1, 0, hit, pa);
    lookup(39'h5000, 16'd1, 44'h0, 0, 0, 0, 0, hit, pa);
    chk("plru_hit_way0", hit, 1);
    lookup(39'hD000, 16'd1, 44'h30, 0, 0, 0, 2, hit, pa);
    lookup(39'h5004, 16'd1, 44'h0, 0, 0, 0, 0, hit, pa);
    chk("plru_way0_kept", hit, 1);
    chk("plru_way0_paddr", pa, 56'h10004);
    lookup(39'h9000, 16'd1, 44'h21, 0, 0, 0, 0, hit, pa);
    chk("plru_way1_evicted", hit, 0);

    // Global page across ASIDs and flushes
    flush(0, 0, 0, 0);
    lookup(39'h7000, 16'd1, 44'h77, 1, 0, 0, 0, hit, pa);
    lookup(39'h7456, 16'd2, 44'h0, 0, 0, 0, 0, hit, pa);
    chk("global_other_asid", hit, 1);
    chk("global_paddr", pa, 56'h77456);
    flush(1, 16'd1, 0, 0);
    lookup(39'h7456, 16'd2, 44'h0, 0, 0, 0, 0, hit, pa);
    chk("global_survives_asid_flush", hit, 1);
    flush(0, 0, 0, 0);
    lookup(39'h7456, 16'd2, 44'h78, 0, 0, 0, 0, hit, pa);
    chk("global_flushed_all", hit, 0);

    // Flush by vaddr
    flush(0, 0, 0, 0);
    lookup(39'h5000, 16'd1, 44'h50, 0, 0, 0, 0, hit, pa);
    lookup(39'h6000, 16'd1, 44'h60, 0, 0, 0, 0, hit, pa);
    flush(0, 0, 1, 39'h5000);
    lookup(39'h6abc, 16'd1, 44'h0, 0, 0, 0, 0, hit, pa);
    chk("vflush_other_hits", hit, 1);
    lookup(39'h5000, 16'd1, 44'h51, 0, 0, 0, 0, hit, pa);
    chk("vflush_target_miss", hit, 0);

    // Page fault with a stalled PTW request channel
    flush(0, 0, 0, 0);
    lookup(39'h3000, 16'd1, 44'h33, 0, 1, 10, 1, hit, pa);
    chk("fault_paddr_zero", pa, 0);
    lookup(39'h3000, 16'd1, 44'h34, 0, 1, 0, 0, hit, pa);
    chk("fault_no_fill", hit, 0);

    // Randomized traffic over a small VPN pool so sets and ways collide
    for (int i = 0; i < 60; i++) begin
      rvpn = VPN_W'($urandom_range(1, 16));
      rva  = (VA_W'(rvpn) << OFF_W) | VA_W'($urandom_range(0, 4095));
      if (i % 8 == 7)
        flush($urandom_range(0, 1), AS_W'($urandom_range(1, 3)), $urandom_range(0, 1), rva);
      lookup(rva, AS_W'($urandom_range(1, 3)), PPN_W'($urandom),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3), hit, pa);
    end

    // Reset during a walk
    lookup(39'h2345, 16'd1, 44'h23, 0, 0, 0, 0, hit, pa);
    flush(1, 16'd9, 1, 39'h8000);
    @(negedge clk);
    tif.i_req_valid = 1'b1; tif.i_vaddr = 39'h8000; tif.i_asid = 16'd1;
    @(negedge clk);
    tif.i_req_valid = 1'b0;
    @(negedge clk);
    chk("mid_ptw_req", tif.o_ptw_req_valid, 1);
    tif.i_ptw_req_ready = 1'b1;
    @(negedge clk);
    tif.i_ptw_req_ready = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", tif.o_req_ready, 1);
    chk("mid_rst_ptw_valid", tif.o_ptw_req_valid, 0);
    chk("mid_rst_ptw_vaddr", tif.o_ptw_req_vaddr, 0);
    chk("mid_rst_resp", tif.o_resp_valid, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_clear();
    tif.i_ptw_resp_valid = 1'b1;
    tif.i_ptw_resp_ppn   = 44'h99;
    @(negedge clk);
    tif.i_ptw_resp_valid = 1'b0;
    chk("late_resp_ignored", tif.o_resp_valid, 0);
    chk("late_resp_ready", tif.o_req_ready, 1);
    lookup(39'h2345, 16'd1, 44'h24, 0, 0, 0, 0, hit, pa);
    chk("post_rst_miss_a", hit, 0);
    lookup(39'h8000, 16'd1, 44'h80, 0, 0, 0, 0, hit, pa);
    chk("post_rst_miss_b", hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
